// File: rtl/reg_file_pkg.sv
// Shared constants, types and helpers for the 8 x 8-bit CPU register file.
// The optional write-to-read bypass is enabled by defining REG_FILE_BYPASS_EN.
package reg_file_pkg;

    localparam int unsigned REG_W    = 8;
    localparam int unsigned REG_AW   = 3;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned CNT_W    = 8;

    // Nominal timing (ns). Zero-delay RTL meets these as upper bounds.
    localparam int unsigned RD_DELAY = 2;
    localparam int unsigned WR_DELAY = 1;

    typedef logic [REG_W-1:0]  reg_data_t;
    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]  wr_count_t;

    function automatic logic [NUM_REGS-1:0] addr_to_onehot(input reg_addr_t addr);
        logic [NUM_REGS-1:0] onehot;
        onehot       = '0;
        onehot[addr] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Write/read bus of the register file. master = CPU datapath side, slave = register file.
interface reg_file_if;
    import reg_file_pkg::*;

    logic      WRITE;
    reg_data_t IN;
    reg_addr_t INADDRESS;
    reg_addr_t OUT1ADDRESS;
    reg_addr_t OUT2ADDRESS;
    reg_data_t OUT1;
    reg_data_t OUT2;
    logic      RD_UNINIT;
    wr_count_t WR_COUNT;

    modport master (
        output WRITE, IN, INADDRESS, OUT1ADDRESS, OUT2ADDRESS,
        input  OUT1, OUT2, RD_UNINIT, WR_COUNT
    );

    modport slave (
        input  WRITE, IN, INADDRESS, OUT1ADDRESS, OUT2ADDRESS,
        output OUT1, OUT2, RD_UNINIT, WR_COUNT
    );

endinterface

// File: rtl/reg_file_reg8.sv
// One 8-bit register with synchronous active-low clear, write enable and a
// "written since reset" valid bit.
module reg_file_reg8
    import reg_file_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      we_i,
    input  reg_data_t d_i,
    output reg_data_t q_o,
    output logic      valid_o
);

    reg_data_t data_d, data_q;
    logic      valid_d, valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (we_i) begin
            data_d  = d_i;
            valid_d = 1'b1;
        end
    end

    // Clear has priority over a write on the same edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        q_o     = data_q;
        valid_o = valid_q;
    end

endmodule

// File: rtl/reg_file.sv
// 8 x 8-bit register file: two combinational read ports, one clocked write port,
// uninitialised-read flag and write counter. Define REG_FILE_BYPASS_EN for write-to-read bypass.
module reg_file
    import reg_file_pkg::*;
(
    input logic        CLK,
    input logic        RESET_N,
    reg_file_if.slave  bus
);

    logic [NUM_REGS-1:0] we;
    logic [NUM_REGS-1:0] valid;
    reg_data_t           regs [NUM_REGS];
    wr_count_t           wr_count_d, wr_count_q;
    reg_data_t           out1, out2;
    logic                valid1, valid2;

    always_comb begin
        we = '0;
        if (bus.WRITE) begin
            we = addr_to_onehot(bus.INADDRESS);
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        reg_file_reg8 u_reg (
            .clk_i   (CLK),
            .rst_ni  (RESET_N),
            .we_i    (we[i]),
            .d_i     (bus.IN),
            .q_o     (regs[i]),
            .valid_o (valid[i])
        );
    end

    always_comb begin
        out1   = regs[bus.OUT1ADDRESS];
        out2   = regs[bus.OUT2ADDRESS];
        valid1 = valid[bus.OUT1ADDRESS];
        valid2 = valid[bus.OUT2ADDRESS];
`ifdef REG_FILE_BYPASS_EN
        // Forward the pending write so the ALU sees it in the same cycle.
        if (bus.WRITE && RESET_N && (bus.OUT1ADDRESS == bus.INADDRESS)) begin
            out1   = bus.IN;
            valid1 = 1'b1;
        end
        if (bus.WRITE && RESET_N && (bus.OUT2ADDRESS == bus.INADDRESS)) begin
            out2   = bus.IN;
            valid2 = 1'b1;
        end
`endif
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (bus.WRITE) begin
            wr_count_d = wr_count_q + wr_count_t'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    always_comb begin
        bus.OUT1      = out1;
        bus.OUT2      = out2;
        bus.RD_UNINIT = ~valid1 | ~valid2;
        bus.WR_COUNT  = wr_count_q;
    end

endmodule
